carrd_v_issue_seq: RTL and testbench
====================================

Name: carrd_v_issue_seq

Overview:
- Issue-side sequencer for the vector coprocessor, and the initiator counterpart of carrd_writeback.
- Accepts one decoded vector instruction at a time and launches it on exactly one functional unit: VLANES (ALU/MUL), VRED, SLDU or LSU.
- Waits for that unit's done and then presents the op fields with a one-cycle done strobe to carrd_writeback, which derives v_sel_dest, v_reg_wr_en and x_reg_wr_en.
- Supports one instruction in flight; upstream is stalled through a valid/ready handshake.

Parameters:
- VREG_AW, 5, vector register address width.
- VL_W, 7, vector length field width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- instr_valid  in  1  decoded instruction available.
- instr_ready  out  1  sequencer can accept an instruction.
- in_v_alu_op  in  4  ALU op; 0 = none.
- in_is_mul  in  1  ALU op uses the multiplier.
- in_v_lsu_op  in  4  LSU op; 0 = none.
- in_v_sldu_op  in  3  slide op; 0 = none.
- in_v_red_op  in  3  reduction op; 0 = none.
- in_vd  in  VREG_AW  destination register.
- in_vl  in  VL_W  vector length.
- start_vlanes, start_vred, start_sldu, start_lsu  out  1 each  one-cycle launch pulses.
- done_vlanes, done_vred, done_sldu, done_lsu  in  1 each  unit completion pulses.
- v_alu_op  out  4  latched op fields presented to writeback.
- is_mul  out  1  latched field presented to writeback.
- v_lsu_op  out  4  latched field presented to writeback.
- v_sldu_op  out  3  latched field presented to writeback.
- v_red_op  out  3  latched field presented to writeback.
- wb_vd  out  VREG_AW  latched destination register.
- wb_vl  out  VL_W  latched vector length.
- wb_done_vlanes  out  1  one-cycle strobe to writeback done_vlanes.
- wb_done_vred  out  1  one-cycle strobe to writeback done_vred.
- wb_valid  out  1  one-cycle strobe; writeback fields valid.
- busy  out  1  instruction in flight.
- multi_op_err  out  1  sticky; more than one op field was nonzero.
- timeout_err  out  1  sticky; see Optional Feature.

Behaviour:
- Reset (synchronous, active-high, clk rising edge): state IDLE; all outputs 0 except instr_ready=1; sticky errors cleared.
- Reset mid-operation aborts the in-flight instruction: no start or wb pulse is produced, and a late done from the aborted unit is ignored.
- FSM states: IDLE, ISSUE, WAIT, WB.
- IDLE: instr_ready=1. On instr_valid && instr_ready (cycle N), latch all in_* fields and select the unit with fixed priority LSU > SLDU > RED > ALU.
  - If more than one op field is nonzero, set multi_op_err and use the priority winner.
  - If all op fields are 0 (NOP), go straight to WB with no start pulse.
  - Otherwise go to ISSUE.
- ISSUE (cycle N+1): assert start_<unit> for exactly one cycle, then go to WAIT. Done inputs are ignored in ISSUE; units have at least 1 cycle of latency.
- WAIT: busy=1. Only the selected unit's done is honoured; done from other units is ignored. On that done, go to WB.
- WB (one cycle): wb_valid=1.
  - wb_done_vlanes=1 if the unit was ALU, SLDU or LSU (these complete through the lanes).
  - wb_done_vred=1 if the unit was RED.
  - NOP: wb_valid=1 with both done strobes 0.
  - Op fields, wb_vd and wb_vl stay stable from the cycle after acceptance until the next acceptance; writeback decodes them combinationally.
  - Next state: IDLE.
- instr_ready is combinational: (state==IDLE). There is no bypass from WB.
- Minimum turnaround is accept N, start N+1, done ≥N+2, WB the cycle after done, next accept the cycle after WB.
- Throughput limit: one instruction per 4 cycles.
- busy = (state != IDLE).

Optional Feature:
- Macro: CARRD_ISSUE_TIMEOUT_EN.
- Defined:
  - A 16-bit watchdog counter clears on entry to WAIT and increments each WAIT cycle.
  - At 65535 without a done: set timeout_err sticky, return to IDLE, and emit no wb pulse.
  - A done in the same cycle as expiry wins: normal WB, no error.
- Not defined: WAIT lasts indefinitely, timeout_err is tied to 0, and no counter logic is generated.

Decomposition:
- v_pkg holds:
  - the issue FSM state enum;
  - unit-select enum (U_NONE, U_ALU, U_RED, U_SLDU, U_LSU);
  - op-field widths;
  - OP_NONE=0 constants;
  - the watchdog limit constant.
- Optional sub-module carrd_issue_sel: combinational priority select plus multi-op detect, producing the unit enum and the error flag.

Test Plan:
- ALU add, in_v_alu_op=1: accept N, start_vlanes at N+1, done_vlanes at N+3 → at N+4 wb_valid=1, wb_done_vlanes=1, v_alu_op=1, instr_ready=1 again at N+5.
- Reduction, in_v_red_op=2: start_vred pulses once → done_vred → wb_done_vred=1 and wb_done_vlanes=0; a spurious done_vlanes in WAIT is ignored.
- in_v_sldu_op=1 and in_v_lsu_op=3 together → start_lsu only, multi_op_err=1 (sticky until rst).
- NOP (all op fields 0) → no start pulse; wb_valid at N+1 with both done strobes 0.
- rst asserted during WAIT → next cycle all outputs at reset values, instr_ready=1; a following done_lsu produces no wb_valid.
- With CARRD_ISSUE_TIMEOUT_EN and no done for 65535 WAIT cycles → timeout_err=1, return to IDLE, no wb_valid.

Source files
------------

// File: rtl/carrd_v_issue_seq_pkg.sv
// carrd_v_issue_seq_pkg: shared types and constants for the vector issue sequencer.
// Holds FSM state codes, unit-select enum, op-field widths and the watchdog limit.
package carrd_v_issue_seq_pkg;

    localparam int ALU_OP_W  = 4;
    localparam int LSU_OP_W  = 4;
    localparam int SLDU_OP_W = 3;
    localparam int RED_OP_W  = 3;

    localparam logic [ALU_OP_W-1:0]  ALU_OP_NONE  = '0;
    localparam logic [LSU_OP_W-1:0]  LSU_OP_NONE  = '0;
    localparam logic [SLDU_OP_W-1:0] SLDU_OP_NONE = '0;
    localparam logic [RED_OP_W-1:0]  RED_OP_NONE  = '0;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_WB    = 2'd3;

    typedef enum logic [2:0] {
        U_NONE = 3'd0,
        U_ALU  = 3'd1,
        U_RED  = 3'd2,
        U_SLDU = 3'd3,
        U_LSU  = 3'd4
    } unit_e;

    localparam int         WD_W     = 16;
    localparam logic [WD_W-1:0] WD_LIMIT = 16'hFFFF;

    // ALU, slide and LSU results all retire through the lane datapath.
    function automatic logic unit_uses_lanes(input unit_e u);
        return (u == U_ALU) || (u == U_SLDU) || (u == U_LSU);
    endfunction

endpackage

// File: rtl/carrd_v_issue_seq_sel.sv
// carrd_issue_sel: fixed-priority unit select (LSU > SLDU > RED > ALU).
// Also flags instructions that carry more than one nonzero op field.
module carrd_issue_sel
    import carrd_v_issue_seq_pkg::*;
(
    input  logic [ALU_OP_W-1:0]  v_alu_op,
    input  logic [LSU_OP_W-1:0]  v_lsu_op,
    input  logic [SLDU_OP_W-1:0] v_sldu_op,
    input  logic [RED_OP_W-1:0]  v_red_op,
    output unit_e                unit,
    output logic                 multi_op
);

    logic [3:0] nz;

    // Priority winner plus a more-than-one-bit-set test on the nonzero mask.
    always_comb begin
        nz = {v_lsu_op  != LSU_OP_NONE,
              v_sldu_op != SLDU_OP_NONE,
              v_red_op  != RED_OP_NONE,
              v_alu_op  != ALU_OP_NONE};
        multi_op = (nz & (nz - 4'd1)) != 4'd0;
        if (nz[3])
            unit = U_LSU;
        else if (nz[2])
            unit = U_SLDU;
        else if (nz[1])
            unit = U_RED;
        else if (nz[0])
            unit = U_ALU;
        else
            unit = U_NONE;
    end

endmodule

// File: rtl/carrd_v_issue_seq.sv
// carrd_v_issue_seq: single-in-flight issue sequencer for the vector coprocessor.
// Optional watchdog in WAIT enabled by defining CARRD_ISSUE_TIMEOUT_EN.
module carrd_v_issue_seq
    import carrd_v_issue_seq_pkg::*;
#(
    parameter int VREG_AW = 5,
    parameter int VL_W    = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    input  logic [ALU_OP_W-1:0]  in_v_alu_op,
    input  logic                 in_is_mul,
    input  logic [LSU_OP_W-1:0]  in_v_lsu_op,
    input  logic [SLDU_OP_W-1:0] in_v_sldu_op,
    input  logic [RED_OP_W-1:0]  in_v_red_op,
    input  logic [VREG_AW-1:0]   in_vd,
    input  logic [VL_W-1:0]      in_vl,
    output logic                 start_vlanes,
    output logic                 start_vred,
    output logic                 start_sldu,
    output logic                 start_lsu,
    input  logic                 done_vlanes,
    input  logic                 done_vred,
    input  logic                 done_sldu,
    input  logic                 done_lsu,
    output logic [ALU_OP_W-1:0]  v_alu_op,
    output logic                 is_mul,
    output logic [LSU_OP_W-1:0]  v_lsu_op,
    output logic [SLDU_OP_W-1:0] v_sldu_op,
    output logic [RED_OP_W-1:0]  v_red_op,
    output logic [VREG_AW-1:0]   wb_vd,
    output logic [VL_W-1:0]      wb_vl,
    output logic                 wb_done_vlanes,
    output logic                 wb_done_vred,
    output logic                 wb_valid,
    output logic                 busy,
    output logic                 multi_op_err,
    output logic                 timeout_err
);

    logic [1:0] state;
    logic [1:0] state_nx;
    unit_e      unit_q;
    unit_e      sel_unit;
    logic       sel_multi;
    logic       accept;
    logic       sel_done;
    logic       expire;

    carrd_issue_sel u_sel (
        .v_alu_op  (in_v_alu_op),
        .v_lsu_op  (in_v_lsu_op),
        .v_sldu_op (in_v_sldu_op),
        .v_red_op  (in_v_red_op),
        .unit      (sel_unit),
        .multi_op  (sel_multi)
    );

    assign instr_ready = (state == S_IDLE);
    assign busy        = (state != S_IDLE);
    assign accept      = instr_valid && instr_ready;

    // Only the launched unit's done can end the WAIT phase.
    always_comb begin
        unique case (unit_q)
            U_ALU:   sel_done = done_vlanes;
            U_RED:   sel_done = done_vred;
            U_SLDU:  sel_done = done_sldu;
            U_LSU:   sel_done = done_lsu;
            default: sel_done = 1'b0;
        endcase
    end

`ifdef CARRD_ISSUE_TIMEOUT_EN
    logic [WD_W-1:0] wd_cnt;

    // A done arriving on the expiry cycle takes precedence over the timeout.
    assign expire = (state == S_WAIT) && !sel_done && (wd_cnt == WD_LIMIT);

    // Watchdog counts WAIT cycles; cleared while launching so it starts at 0.
    always_ff @(posedge clk) begin
        if (rst)
            wd_cnt <= '0;
        else if (state == S_ISSUE)
            wd_cnt <= '0;
        else if (state == S_WAIT)
            wd_cnt <= wd_cnt + 16'd1;
    end

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst)
            timeout_err <= 1'b0;
        else if (expire)
            timeout_err <= 1'b1;
    end
`else
    assign expire      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Next-state logic; NOPs skip the launch and wait phases entirely.
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (accept)
                    state_nx = (sel_unit == U_NONE) ? S_WB : S_ISSUE;
            end
            S_ISSUE: state_nx = S_WAIT;
            S_WAIT: begin
                if (sel_done)
                    state_nx = S_WB;
                else if (expire)
                    state_nx = S_IDLE;
            end
            S_WB:    state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    // Latch op fields and the chosen unit at acceptance; held until the next one.
    always_ff @(posedge clk) begin
        if (rst) begin
            unit_q    <= U_NONE;
            v_alu_op  <= ALU_OP_NONE;
            is_mul    <= 1'b0;
            v_lsu_op  <= LSU_OP_NONE;
            v_sldu_op <= SLDU_OP_NONE;
            v_red_op  <= RED_OP_NONE;
            wb_vd     <= '0;
            wb_vl     <= '0;
        end else if (accept) begin
            unit_q    <= sel_unit;
            v_alu_op  <= in_v_alu_op;
            is_mul    <= in_is_mul;
            v_lsu_op  <= in_v_lsu_op;
            v_sldu_op <= in_v_sldu_op;
            v_red_op  <= in_v_red_op;
            wb_vd     <= in_vd;
            wb_vl     <= in_vl;
        end
    end

    // Sticky flag for instructions carrying several op fields.
    always_ff @(posedge clk) begin
        if (rst)
            multi_op_err <= 1'b0;
        else if (accept && sel_multi)
            multi_op_err <= 1'b1;
    end

    assign start_vlanes = (state == S_ISSUE) && (unit_q == U_ALU);
    assign start_vred   = (state == S_ISSUE) && (unit_q == U_RED);
    assign start_sldu   = (state == S_ISSUE) && (unit_q == U_SLDU);
    assign start_lsu    = (state == S_ISSUE) && (unit_q == U_LSU);

    assign wb_valid       = (state == S_WB);
    assign wb_done_vlanes = wb_valid && unit_uses_lanes(unit_q);
    assign wb_done_vred   = wb_valid && (unit_q == U_RED);

endmodule

// File: tb/tb_carrd_v_issue_seq.sv
// tb_carrd_v_issue_seq: directed table plus randomized transactions
// checked against a priority/stickiness model of the issue sequencer.
module tb_carrd_v_issue_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       instr_valid;
    logic       instr_ready;
    logic [3:0] in_v_alu_op;
    logic       in_is_mul;
    logic [3:0] in_v_lsu_op;
    logic [2:0] in_v_sldu_op;
    logic [2:0] in_v_red_op;
    logic [4:0] in_vd;
    logic [6:0] in_vl;
    logic       start_vlanes, start_vred, start_sldu, start_lsu;
    logic       done_vlanes, done_vred, done_sldu, done_lsu;
    logic [3:0] v_alu_op;
    logic       is_mul;
    logic [3:0] v_lsu_op;
    logic [2:0] v_sldu_op;
    logic [2:0] v_red_op;
    logic [4:0] wb_vd;
    logic [6:0] wb_vl;
    logic       wb_done_vlanes, wb_done_vred, wb_valid;
    logic       busy, multi_op_err, timeout_err;

    int n_vec = 0;
    int n_err = 0;
    bit exp_multi = 1'b0;

    always #5 clk = ~clk;

    carrd_v_issue_seq dut (
        .clk            (clk),
        .rst            (rst),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .in_v_alu_op    (in_v_alu_op),
        .in_is_mul      (in_is_mul),
        .in_v_lsu_op    (in_v_lsu_op),
        .in_v_sldu_op   (in_v_sldu_op),
        .in_v_red_op    (in_v_red_op),
        .in_vd          (in_vd),
        .in_vl          (in_vl),
        .start_vlanes   (start_vlanes),
        .start_vred     (start_vred),
        .start_sldu     (start_sldu),
        .start_lsu      (start_lsu),
        .done_vlanes    (done_vlanes),
        .done_vred      (done_vred),
        .done_sldu      (done_sldu),
        .done_lsu       (done_lsu),
        .v_alu_op       (v_alu_op),
        .is_mul         (is_mul),
        .v_lsu_op       (v_lsu_op),
        .v_sldu_op      (v_sldu_op),
        .v_red_op       (v_red_op),
        .wb_vd          (wb_vd),
        .wb_vl          (wb_vl),
        .wb_done_vlanes (wb_done_vlanes),
        .wb_done_vred   (wb_done_vred),
        .wb_valid       (wb_valid),
        .busy           (busy),
        .multi_op_err   (multi_op_err),
        .timeout_err    (timeout_err)
    );

    // unit codes: 0 none, 1 ALU, 2 RED, 3 SLDU, 4 LSU
    typedef struct {
        logic [3:0] alu;
        logic       mul;
        logic [3:0] lsu;
        logic [2:0] sldu;
        logic [2:0] red;
        logic [4:0] vd;
        logic [6:0] vl;
        int         dly;
        bit         spur;
        int         exp_unit;
        bit         exp_multi;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int model_unit(input vec_t v);
        if (v.lsu != 0) return 4;
        if (v.sldu != 0) return 3;
        if (v.red != 0) return 2;
        if (v.alu != 0) return 1;
        return 0;
    endfunction

    function automatic bit model_multi(input vec_t v);
        int c;
        c = int'(v.lsu != 0) + int'(v.sldu != 0) + int'(v.red != 0) + int'(v.alu != 0);
        return c > 1;
    endfunction

    function automatic logic [3:0] onehot(input int u);
        logic [3:0] r;
        r = 4'd0;
        if (u > 0) r[u-1] = 1'b1;
        return r;
    endfunction

    function automatic logic [26:0] fields(input vec_t v);
        return {v.alu, v.mul, v.lsu, v.sldu, v.red, v.vd, v.vl};
    endfunction

    task automatic set_done(input logic [3:0] d);
        {done_lsu, done_sldu, done_vred, done_vlanes} = d;
    endtask

    task automatic scramble();
        in_v_alu_op  = 4'($urandom);
        in_is_mul    = 1'($urandom);
        in_v_lsu_op  = 4'($urandom);
        in_v_sldu_op = 3'($urandom);
        in_v_red_op  = 3'($urandom);
        in_vd        = 5'($urandom);
        in_vl        = 7'($urandom);
    endtask

    // One full transaction: accept, launch, wait, done, writeback.
    task automatic run(input vec_t v, input int eu, input bit em);
        logic [3:0] st;
        logic [3:0] others;
        st = onehot(eu);
        others = 4'hF & ~st;
        @(negedge clk);
        chk("ready_idle", instr_ready, 1);
        chk("busy_idle", busy, 0);
        instr_valid  = 1'b1;
        in_v_alu_op  = v.alu;
        in_is_mul    = v.mul;
        in_v_lsu_op  = v.lsu;
        in_v_sldu_op = v.sldu;
        in_v_red_op  = v.red;
        in_vd        = v.vd;
        in_vl        = v.vl;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        scramble();
        if (eu != 0) begin
            @(negedge clk);
            chk("start_issue", {start_lsu, start_sldu, start_vred, start_vlanes}, st);
            chk("ready_issue", instr_ready, 0);
            if (v.spur) set_done(others);
            @(posedge clk);
            for (int d = 0; d < v.dly; d++) begin
                @(negedge clk);
                chk("start_wait", {start_lsu, start_sldu, start_vred, start_vlanes}, 0);
                chk("wb_wait", wb_valid, 0);
                set_done(v.spur ? others : 4'd0);
                @(posedge clk);
            end
            @(negedge clk);
            chk("busy_wait", busy, 1);
            chk("wb_wait", wb_valid, 0);
            set_done(st);
            @(posedge clk);
            #1;
            set_done(4'd0);
        end
        @(negedge clk);
        chk("start_wb", {start_lsu, start_sldu, start_vred, start_vlanes}, 0);
        chk("wb_valid", wb_valid, 1);
        chk("wb_strobes", {wb_done_vlanes, wb_done_vred},
            {(eu == 1 || eu == 3 || eu == 4), (eu == 2)});
        chk("wb_fields", {v_alu_op, is_mul, v_lsu_op, v_sldu_op, v_red_op, wb_vd, wb_vl},
            fields(v));
        chk("multi_err", multi_op_err, em);
        chk("ready_wb", instr_ready, 0);
        @(posedge clk);
    endtask

    initial begin
        vec_t v;
        int eu;
        rst = 1'b1;
        instr_valid = 1'b0;
        set_done(4'd0);
        scramble();

        tbl[0] = '{alu:1, mul:0, lsu:0, sldu:0, red:0, vd:3,  vl:16,  dly:1, spur:0, exp_unit:1, exp_multi:0};
        tbl[1] = '{alu:0, mul:0, lsu:0, sldu:0, red:2, vd:7,  vl:32,  dly:2, spur:1, exp_unit:2, exp_multi:0};
        tbl[2] = '{alu:0, mul:1, lsu:0, sldu:0, red:0, vd:9,  vl:5,   dly:0, spur:0, exp_unit:0, exp_multi:0};
        tbl[3] = '{alu:0, mul:0, lsu:0, sldu:4, red:0, vd:31, vl:127, dly:0, spur:1, exp_unit:3, exp_multi:0};
        tbl[4] = '{alu:0, mul:1, lsu:5, sldu:0, red:0, vd:1,  vl:1,   dly:3, spur:1, exp_unit:4, exp_multi:0};
        tbl[5] = '{alu:0, mul:0, lsu:3, sldu:1, red:0, vd:12, vl:64,  dly:1, spur:1, exp_unit:4, exp_multi:1};
        tbl[6] = '{alu:2, mul:0, lsu:0, sldu:0, red:1, vd:20, vl:8,   dly:0, spur:1, exp_unit:2, exp_multi:1};
        tbl[7] = '{alu:7, mul:1, lsu:0, sldu:0, red:0, vd:0,  vl:0,   dly:2, spur:0, exp_unit:1, exp_multi:1};

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", instr_ready, 1);
        chk("rst_outs", {start_lsu, start_sldu, start_vred, start_vlanes, wb_valid,
                         wb_done_vlanes, wb_done_vred, busy, multi_op_err, timeout_err,
                         v_alu_op, is_mul, v_lsu_op, v_sldu_op, v_red_op, wb_vd, wb_vl}, 0);

        for (int i = 0; i < 8; i++)
            run(tbl[i], tbl[i].exp_unit, tbl[i].exp_multi);
        exp_multi = 1'b1;

        // Reset while waiting on the LSU; the late done must not retire anything.
        @(negedge clk);
        instr_valid = 1'b1;
        in_v_lsu_op = 4'd2;
        in_v_alu_op = 4'd1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_pre_busy", busy, 1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_ready", instr_ready, 1);
        chk("rst_mid_outs", {start_lsu, start_sldu, start_vred, start_vlanes, wb_valid,
                             wb_done_vlanes, wb_done_vred, busy, multi_op_err, timeout_err,
                             v_alu_op, is_mul, v_lsu_op, v_sldu_op, v_red_op, wb_vd, wb_vl}, 0);
        set_done(4'b1000);
        @(posedge clk);
        #1 set_done(4'd0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("late_done_wb", wb_valid, 0);
            chk("late_done_busy", busy, 0);
        end
        exp_multi = 1'b0;

        for (int i = 0; i < 40; i++) begin
            v.alu  = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            v.lsu  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            v.sldu = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            v.red  = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            v.mul  = 1'($urandom);
            v.vd   = 5'($urandom);
            v.vl   = 7'($urandom);
            v.dly  = $urandom_range(0, 4);
            v.spur = 1'($urandom);
            eu = model_unit(v);
            exp_multi = exp_multi | model_multi(v);
            run(v, eu, exp_multi);
        end

        @(negedge clk);
        chk("timeout_err", timeout_err, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
